// File: rtl/instruction_cache.sv
// Read-only direct-mapped instruction cache with 4-word lines.
// A hit returns the addressed word combinationally. A miss stalls the fetch stage
// while one line is read from instruction memory.
module instruction_cache #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          proc_read,
    input  logic [29:0]   proc_addr,
    output logic [31:0]   proc_rdata,
    output logic          proc_stall,
    output logic          mem_read,
    output logic [27:0]   mem_addr,
    input  logic [127:0]  mem_rdata,
    input  logic          mem_ready
);

    localparam int unsigned Lines = 1 << INDEX_W;

    typedef enum logic [0:0] {StIdle, StFetch} state_e;

    state_e state_q, state_d;

    logic [Lines-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [Lines];
    logic [127:0]     data_q [Lines];

    logic             mem_read_q;
    logic [27:0]      mem_addr_q;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         req_word;
    logic               hit;
    logic               fill;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;

    assign req_tag    = proc_addr[29:INDEX_W+2];
    assign req_index  = proc_addr[INDEX_W+1:2];
    assign req_word   = proc_addr[1:0];
    assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);

    // The fill target comes from the latched request, not the live address,
    // so a fetch stage that changes proc_addr mid-refill cannot corrupt it.
    assign fill       = (state_q == StFetch) && mem_ready;
    assign fill_index = mem_addr_q[INDEX_W-1:0];
    assign fill_tag   = mem_addr_q[27:INDEX_W];

    assign mem_read   = mem_read_q;
    assign mem_addr   = mem_addr_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave IDLE on a miss, return once the line arrives.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (proc_read && !hit) state_d = StFetch;
            StFetch: if (mem_ready)         state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs toward the fetch stage: zero-latency word on a hit, stall otherwise.
    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = '0;
        unique case (state_q)
            StIdle: begin
                if (proc_read) begin
                    if (hit) begin
                        proc_rdata = data_q[req_index][{req_word, 5'd0} +: 32];
                    end else begin
                        proc_stall = 1'b1;
                    end
                end
            end
            StFetch: proc_stall = 1'b1;
            default: ;
        endcase
    end

    // Line request registers: latched on a miss, held until the fill edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else if ((state_q == StIdle) && proc_read && !hit) begin
            mem_read_q <= 1'b1;
            mem_addr_q <= {req_tag, req_index};
        end else if (fill) begin
            mem_read_q <= 1'b0;
        end
    end

    // Valid bits are the only storage that needs a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fill_index] <= 1'b1;
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache.
module tb_instruction_cache;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [127:0] LineA = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] LineB = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LineT = 128'hF00DF00D_CAFEBABE_12345678_9ABCDEF0;

    instruction_cache #(
        .INDEX_W (3),
        .TAG_W   (25)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue a missing read, return the line in the nwait-th FETCH cycle, then check delivery.
    task automatic refill(input string tag, input logic [29:0] addr, input logic [127:0] line,
                          input int nwait, input logic [31:0] exp_word);
        int stalls;
        stalls = 0;
        proc_read = 1'b1;
        proc_addr = addr;
        #1;
        check_eq({tag, "_miss_stall"}, {31'd0, proc_stall}, 32'd1);
        if (proc_stall) stalls++;
        for (int c = 1; c <= nwait; c++) begin
            tick();
            if (proc_stall) stalls++;
            check_eq({tag, "_mem_read"}, {31'd0, mem_read}, 32'd1);
            check_eq({tag, "_mem_addr"}, {4'd0, mem_addr}, {4'd0, addr[29:2]});
            if (c == nwait) begin
                mem_ready = 1'b1;
                mem_rdata = line;
            end
        end
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        #1;
        check_eq({tag, "_stall_cycles"}, stalls, nwait + 1);
        check_eq({tag, "_stall_drop"}, {31'd0, proc_stall}, 32'd0);
        check_eq({tag, "_rdata"}, proc_rdata, exp_word);
        check_eq({tag, "_mem_read_drop"}, {31'd0, mem_read}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        proc_read = 1'b0;
        proc_addr = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #2;
        check_eq("rst_stall", {31'd0, proc_stall}, 32'd0);
        check_eq("rst_rdata", proc_rdata, 32'd0);
        check_eq("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check_eq("rst_mem_addr", {4'd0, mem_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Cold miss on word 1 of line 1; stall lasts 6 cycles.
        refill("cold", 30'h0000005, LineA, 5, 32'hBBBBBBBB);

        // Hit streak over the filled line.
        for (int i = 0; i < 4; i++) begin
            tick();
            proc_addr = 30'h4 + 30'(i);
            #1;
            check_eq("hit_stall", {31'd0, proc_stall}, 32'd0);
            check_eq("hit_rdata", proc_rdata, LineA[32*i +: 32]);
            check_eq("hit_mem_read", {31'd0, mem_read}, 32'd0);
        end
        tick();

        // Conflict eviction at index 1, then the old line misses again.
        refill("evict", 30'h0000024, LineB, 2, 32'h11111111);
        tick();
        refill("reload", 30'h0000004, LineA, 1, 32'hAAAAAAAA);
        tick();

        // No request on an invalid line: no stall, no memory traffic.
        proc_read = 1'b0;
        proc_addr = 30'h3ABCD14;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("idle_stall", {31'd0, proc_stall}, 32'd0);
            check_eq("idle_mem_read", {31'd0, mem_read}, 32'd0);
        end

        // Reset two cycles into a miss; late mem_ready must not fill the line.
        proc_read = 1'b1;
        proc_addr = 30'h0000010;
        tick();
        check_eq("abort_mem_read_pre", {31'd0, mem_read}, 32'd1);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check_eq("abort_mem_addr", {4'd0, mem_addr}, 32'd0);
        proc_read = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = LineB;
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("late_ready_mem_read", {31'd0, mem_read}, 32'd0);
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        refill("after_rst", 30'h0000010, LineA, 3, 32'hAAAAAAAA);
        tick();
        // Reset also cleared line 1.
        refill("after_rst_l1", 30'h0000004, LineA, 1, 32'hAAAAAAAA);
        tick();

        // Top of the address space: all-ones tag and index, word 3.
        refill("top", 30'h3FFFFFFF, LineT, 2, 32'hF00DF00D);
        tick();
        proc_read = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
